// File: rtl/median_line_buffer_if.sv
// Pixel-stream input and 11-pixel column output bundle of the median line buffer.
// The slave side is the line buffer; the master side is the pixel source / column consumer.
interface median_line_buffer_if #(
   parameter int WIDTH = 9
);
   logic             in_sof;
   logic             in_valid;
   logic [WIDTH-1:0] in_pixel;
   logic             col_clken;
   logic [WIDTH-1:0] col_pix0;
   logic [WIDTH-1:0] col_pix1;
   logic [WIDTH-1:0] col_pix2;
   logic [WIDTH-1:0] col_pix3;
   logic [WIDTH-1:0] col_pix4;
   logic [WIDTH-1:0] col_pix5;
   logic [WIDTH-1:0] col_pix6;
   logic [WIDTH-1:0] col_pix7;
   logic [WIDTH-1:0] col_pix8;
   logic [WIDTH-1:0] col_pix9;
   logic [WIDTH-1:0] col_pix10;
   logic             frame_busy;
   logic             frame_done;

   modport master (
      output in_sof, in_valid, in_pixel,
      input  col_clken, col_pix0, col_pix1, col_pix2, col_pix3, col_pix4, col_pix5,
             col_pix6, col_pix7, col_pix8, col_pix9, col_pix10, frame_busy, frame_done
   );

   modport slave (
      input  in_sof, in_valid, in_pixel,
      output col_clken, col_pix0, col_pix1, col_pix2, col_pix3, col_pix4, col_pix5,
             col_pix6, col_pix7, col_pix8, col_pix9, col_pix10, frame_busy, frame_done
   );
endinterface

// File: rtl/median_line_buffer.sv
// Ten cascaded line delays feeding the 11x11 median window: each accepted raster pixel
// produces one registered vertical column (rows r-10..r) and a strobe once row 10 is reached.
module median_line_buffer #(
   parameter int WIDTH = 9,
   parameter int IMG_W = 640,
   parameter int IMG_H = 480,
   parameter int CW    = $clog2(IMG_W),
   parameter int RW    = $clog2(IMG_H + 1)
) (
   input logic                  clk,
   input logic                  rst,
   median_line_buffer_if.slave  bus
);

   localparam int             NLINES    = 10;
   localparam logic [CW-1:0]  COL_LAST  = CW'(IMG_W - 1);
   localparam logic [CW-1:0]  COL_ONE   = CW'(32'd1);
   localparam logic [RW-1:0]  ROW_LAST  = RW'(IMG_H - 1);
   localparam logic [RW-1:0]  ROW_ONE   = RW'(32'd1);
   localparam logic [RW-1:0]  ROW_FIRST = RW'(32'd10);

   logic [WIDTH-1:0] line_mem_r [1:NLINES][0:IMG_W-1];
   logic [WIDTH-1:0] col_pix_r  [0:NLINES];
   logic [CW-1:0]    col_cnt_r;
   logic [RW-1:0]    row_cnt_r;
   logic             frame_busy_r;
   logic             col_clken_r;
   logic             frame_done_r;

   logic             accept_s;
   logic [CW-1:0]    beat_col_s;
   logic [RW-1:0]    beat_row_s;
   logic             last_col_s;
   logic             last_beat_s;
   logic [CW-1:0]    col_nxt_s;
   logic [RW-1:0]    row_nxt_s;

   // Beat qualification and position; an accepted sof always lands on (row 0, col 0).
   always_comb begin
      accept_s = bus.in_valid & (frame_busy_r | bus.in_sof);
      if (bus.in_sof) begin
         beat_col_s = {CW{1'b0}};
         beat_row_s = {RW{1'b0}};
      end else begin
         beat_col_s = col_cnt_r;
         beat_row_s = row_cnt_r;
      end
      last_col_s  = (beat_col_s == COL_LAST);
      last_beat_s = last_col_s & (beat_row_s == ROW_LAST);
      if (last_col_s) begin
         col_nxt_s = {CW{1'b0}};
         if (beat_row_s == ROW_LAST) begin
            row_nxt_s = {RW{1'b0}};
         end else begin
            row_nxt_s = beat_row_s + ROW_ONE;
         end
      end else begin
         col_nxt_s = beat_col_s + COL_ONE;
         row_nxt_s = beat_row_s;
      end
   end

   // Raster position counters and frame-in-progress flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col_cnt_r    <= {CW{1'b0}};
         row_cnt_r    <= {RW{1'b0}};
         frame_busy_r <= 1'b0;
      end else if (accept_s) begin
         col_cnt_r    <= col_nxt_s;
         row_cnt_r    <= row_nxt_s;
         frame_busy_r <= ~last_beat_s;
      end
   end

   // Cascaded line delay; contents are never reset since rows 0..9 never raise the strobe.
   always_ff @(posedge clk) begin
      if (accept_s) begin
         line_mem_r[1][beat_col_s] <= bus.in_pixel;
         for (int k = 2; k <= NLINES; k++) begin
            line_mem_r[k][beat_col_s] <= line_mem_r[k-1][beat_col_s];
         end
      end
   end

   // Registered column, strobe and end-of-frame pulse; the column holds between beats.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col_clken_r  <= 1'b0;
         frame_done_r <= 1'b0;
         for (int j = 0; j <= NLINES; j++) begin
            col_pix_r[j] <= {WIDTH{1'b0}};
         end
      end else if (accept_s) begin
         col_clken_r       <= (beat_row_s >= ROW_FIRST);
         frame_done_r      <= last_beat_s;
         col_pix_r[NLINES] <= bus.in_pixel;
         for (int k = 1; k <= NLINES; k++) begin
            col_pix_r[NLINES-k] <= line_mem_r[k][beat_col_s];
         end
      end else begin
         col_clken_r  <= 1'b0;
         frame_done_r <= 1'b0;
      end
   end

   assign bus.col_clken  = col_clken_r;
   assign bus.frame_done = frame_done_r;
   assign bus.frame_busy = frame_busy_r;
   assign bus.col_pix0   = col_pix_r[0];
   assign bus.col_pix1   = col_pix_r[1];
   assign bus.col_pix2   = col_pix_r[2];
   assign bus.col_pix3   = col_pix_r[3];
   assign bus.col_pix4   = col_pix_r[4];
   assign bus.col_pix5   = col_pix_r[5];
   assign bus.col_pix6   = col_pix_r[6];
   assign bus.col_pix7   = col_pix_r[7];
   assign bus.col_pix8   = col_pix_r[8];
   assign bus.col_pix9   = col_pix_r[9];
   assign bus.col_pix10  = col_pix_r[10];

endmodule

// File: tb/tb_median_line_buffer.sv
// Directed bench for median_line_buffer on a 16x16 frame; pixel = base + row*16 + col,
// so every column value is known from the raster position alone.
module tb_median_line_buffer;
   localparam int WIDTH = 9;
   localparam int IMG_W = 16;
   localparam int IMG_H = 16;

   logic clk = 1'b0;
   logic rst;

   median_line_buffer_if #(.WIDTH(WIDTH)) bus ();

   median_line_buffer #(.WIDTH(WIDTH), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   logic [WIDTH-1:0] obs_pix [0:10];
   assign obs_pix[0]  = bus.col_pix0;
   assign obs_pix[1]  = bus.col_pix1;
   assign obs_pix[2]  = bus.col_pix2;
   assign obs_pix[3]  = bus.col_pix3;
   assign obs_pix[4]  = bus.col_pix4;
   assign obs_pix[5]  = bus.col_pix5;
   assign obs_pix[6]  = bus.col_pix6;
   assign obs_pix[7]  = bus.col_pix7;
   assign obs_pix[8]  = bus.col_pix8;
   assign obs_pix[9]  = bus.col_pix9;
   assign obs_pix[10] = bus.col_pix10;

   int pass_cnt  = 0;
   int check_cnt = 0;
   int n_clken;
   int n_done;

   // reference state: position of the next beat, frame flag, expected column
   bit m_busy;
   int m_row;
   int m_col;
   int m_base;
   int exp_pix [0:10];
   bit pix_known;

   task automatic check(input string tag, input int got, input int exp);
      check_cnt++;
      if (got == exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic model_reset();
      m_busy = 1'b0;
      m_row = 0;
      m_col = 0;
      m_base = 0;
      for (int j = 0; j <= 10; j++) exp_pix[j] = 0;
      pix_known = 1'b1;
   endtask

   // one clock cycle of stimulus followed by checks of the registered result
   task automatic step(input bit sof, input bit valid, input int base);
      bit acc;
      bit e_clk;
      bit e_done;
      int br;
      int bc;
      acc = valid && (m_busy || sof);
      br = sof ? 0 : m_row;
      bc = sof ? 0 : m_col;
      if (acc && sof) m_base = base;
      bus.in_sof   = sof;
      bus.in_valid = valid;
      bus.in_pixel = WIDTH'(m_base + br * IMG_W + bc);
      e_clk  = 1'b0;
      e_done = 1'b0;
      if (acc) begin
         e_clk  = (br >= 10);
         e_done = (br == IMG_H - 1) && (bc == IMG_W - 1);
         exp_pix[10] = m_base + br * IMG_W + bc;
         pix_known = e_clk;
         if (e_clk) begin
            for (int j = 0; j < 10; j++) exp_pix[j] = m_base + (br - 10 + j) * IMG_W + bc;
         end
         if (bc == IMG_W - 1) begin
            m_col = 0;
            m_row = (br == IMG_H - 1) ? 0 : br + 1;
         end else begin
            m_col = bc + 1;
            m_row = br;
         end
         m_busy = !e_done;
      end
      @(posedge clk);
      #1;
      check("col_clken", int'(bus.col_clken), int'(e_clk));
      check("frame_done", int'(bus.frame_done), int'(e_done));
      check("frame_busy", int'(bus.frame_busy), int'(m_busy));
      if (bus.col_clken) n_clken++;
      if (bus.frame_done) n_done++;
      check("col_pix10", int'(obs_pix[10]), exp_pix[10]);
      if (pix_known) begin
         for (int j = 0; j < 10; j++) check($sformatf("col_pix%0d", j), int'(obs_pix[j]), exp_pix[j]);
      end
   endtask

   task automatic run_frame(input int base, input int gap_pct);
      int guard;
      n_clken = 0;
      n_done  = 0;
      guard   = 0;
      step(1'b1, 1'b1, base);
      while (m_busy && guard < 5000) begin
         step(1'b0, ($urandom_range(0, 99) >= gap_pct), base);
         guard++;
      end
      check("frame_timeout", int'(m_busy), 0);
      check("clken_count", n_clken, (IMG_H - 10) * IMG_W);
      check("done_count", n_done, 1);
   endtask

   // start a frame and stop just before the beat at (sr, sc)
   task automatic run_partial(input int base, input int sr, input int sc);
      n_clken = 0;
      n_done  = 0;
      step(1'b1, 1'b1, base);
      while (!(m_row == sr && m_col == sc)) step(1'b0, 1'b1, base);
      check("partial_done", n_done, 0);
   endtask

   initial begin
      rst = 1'b0;
      bus.in_sof   = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_pixel = '0;
      model_reset();
      #12;
      check("rst_clken", int'(bus.col_clken), 0);
      check("rst_done", int'(bus.frame_done), 0);
      check("rst_busy", int'(bus.frame_busy), 0);
      check("rst_pix0", int'(obs_pix[0]), 0);
      check("rst_pix10", int'(obs_pix[10]), 0);
      @(negedge clk);
      rst = 1'b1;

      // beats without sof while idle are dropped
      for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 0);

      run_frame(0, 0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0);
      run_frame(0, 40);

      // frame A abandoned at (12,5) by frame B
      run_partial(0, 12, 5);
      run_frame(9'h100, 0);

      // back-to-back frames, then sof landing on the last beat of a frame
      run_frame(0, 0);
      run_frame(9'h100, 0);
      run_partial(0, IMG_H - 1, IMG_W - 1);
      run_frame(9'h100, 0);

      // asynchronous reset mid-line at (11,7)
      run_partial(0, 11, 7);
      #2;
      rst = 1'b0;
      #1;
      check("arst_clken", int'(bus.col_clken), 0);
      check("arst_busy", int'(bus.frame_busy), 0);
      check("arst_pix0", int'(obs_pix[0]), 0);
      check("arst_pix10", int'(obs_pix[10]), 0);
      bus.in_valid = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 0);
      run_frame(0, 0);

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end
endmodule
